// File: rtl/wash_disp.sv
// wash_disp: display/alarm stage for the washing-machine controller.
// Converts total-remaining time Tt and phase-remaining time Tm to BCD with a
// double-dabble converter and drives a 4-digit multiplexed 7-segment display
// (digits 3..2 = Tt, digits 1..0 = Tm). Blinks while paused and pulses a
// buzzer when Tt reaches zero.
// Ports:
//   ts   - clock, rising edge        rst  - synchronous active-high reset
//   p    - power (0 = dark, silent)  s    - run level (1 = running)
//   Tt   - total remaining, 0..63    Tm   - phase remaining, 0..31
//   an   - digit enables, active-low one-hot
//   seg  - segments {g,f,e,d,c,b,a}, active-low
//   dp   - decimal point, active-low buzz - buzzer, active-high
module wash_disp #(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 8,
  parameter int BUZZ_CYC  = 10
) (
  input  logic       ts,
  input  logic       rst,
  input  logic       p,
  input  logic       s,
  input  logic [5:0] Tt,
  input  logic [4:0] Tm,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       buzz
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int BUZZ_W  = $clog2(BUZZ_CYC + 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);
  localparam logic [BUZZ_W-1:0]  BUZZ_RELOAD = BUZZ_W'(BUZZ_CYC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} conv_state_t;

  // BCD digit to active-low segment pattern; anything else is blank.
  function automatic logic [6:0] seg_enc(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'd0:    r = 7'h40;
      4'd1:    r = 7'h79;
      4'd2:    r = 7'h24;
      4'd3:    r = 7'h30;
      4'd4:    r = 7'h19;
      4'd5:    r = 7'h12;
      4'd6:    r = 7'h02;
      4'd7:    r = 7'h78;
      4'd8:    r = 7'h00;
      4'd9:    r = 7'h10;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  // One double-dabble step on {tens, units, binary}: add 3 to BCD nibbles >= 5, then shift.
  function automatic logic [13:0] dd_step(input logic [13:0] x);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = x[13:10];
    lo = x[9:6];
    if (hi >= 4'd5) hi = hi + 4'd3;
    else            hi = hi;
    if (lo >= 4'd5) lo = lo + 4'd3;
    else            lo = lo;
    return {hi[2:0], lo, x[5:0], 1'b0};
  endfunction

  conv_state_t       state_r, state_s;
  logic [10:0]       snap_r;
  logic              snap_vld_r;
  logic [2:0]        shift_cnt_r;
  logic [13:0]       tt_sh_r, tm_sh_r;
  logic [3:0]        d3_r, d2_r, d1_r, d0_r;
  logic [SCAN_W-1:0] scan_cnt_r;
  logic [1:0]        idx_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic              blink_ph_r;
  logic [5:0]        prev_tt_r;
  logic [BUZZ_W-1:0] buzz_cnt_r;
  logic [6:0]        seg_s;
  logic              blink_on_s;
  logic              trig_s;

  // Converter state register; power-off behaves like reset.
  always_ff @(posedge ts) begin
    if (rst || !p) state_r <= IDLE;
    else           state_r <= state_s;
  end

  // Converter next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (p && (!snap_vld_r || ({Tt, Tm} != snap_r))) state_s = LOAD;
        else                                             state_s = IDLE;
      end
      LOAD:  state_s = SHIFT;
      SHIFT: begin
        if (shift_cnt_r == 3'd5) state_s = DONE;
        else                     state_s = SHIFT;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Converter datapath: snapshot, six shift steps, atomic digit write.
  always_ff @(posedge ts) begin
    if (rst || !p) begin
      snap_r      <= 11'd0;
      snap_vld_r  <= 1'b0;
      shift_cnt_r <= 3'd0;
      tt_sh_r     <= 14'd0;
      tm_sh_r     <= 14'd0;
      d3_r        <= 4'd0;
      d2_r        <= 4'd0;
      d1_r        <= 4'd0;
      d0_r        <= 4'd0;
    end else begin
      case (state_r)
        LOAD: begin
          snap_r      <= {Tt, Tm};
          snap_vld_r  <= 1'b1;
          tt_sh_r     <= {8'd0, Tt};
          tm_sh_r     <= {8'd0, 1'b0, Tm};
          shift_cnt_r <= 3'd0;
        end
        SHIFT: begin
          tt_sh_r     <= dd_step(tt_sh_r);
          tm_sh_r     <= dd_step(tm_sh_r);
          shift_cnt_r <= shift_cnt_r + 3'd1;
        end
        DONE: begin
          d3_r <= tt_sh_r[13:10];
          d2_r <= tt_sh_r[9:6];
          d1_r <= tm_sh_r[13:10];
          d0_r <= tm_sh_r[9:6];
        end
        default: begin
          snap_r <= snap_r;
        end
      endcase
    end
  end

  // Segment pattern for the currently selected digit; tens digits blank on zero.
  always_comb begin
    seg_s = 7'h7F;
    case (idx_r)
      2'd3:    seg_s = (d3_r == 4'd0) ? 7'h7F : seg_enc(d3_r);
      2'd2:    seg_s = seg_enc(d2_r);
      2'd1:    seg_s = (d1_r == 4'd0) ? 7'h7F : seg_enc(d1_r);
      2'd0:    seg_s = seg_enc(d0_r);
      default: seg_s = 7'h7F;
    endcase
  end

  assign blink_on_s = !s && (Tt != 6'd0);
  assign trig_s     = (prev_tt_r != 6'd0) && (Tt == 6'd0);

  // Scan, blink, buzzer and registered display outputs.
  always_ff @(posedge ts) begin
    if (rst || !p) begin
      scan_cnt_r  <= '0;
      idx_r       <= 2'd0;
      blink_cnt_r <= '0;
      blink_ph_r  <= 1'b0;
      prev_tt_r   <= 6'd0;
      buzz_cnt_r  <= '0;
      buzz        <= 1'b0;
      an          <= 4'b1111;
      seg         <= 7'h7F;
      dp          <= 1'b1;
    end else begin
      if (scan_cnt_r == SCAN_LAST) begin
        scan_cnt_r <= '0;
        idx_r      <= idx_r + 2'd1;
      end else begin
        scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
      end

      // Blink phase restarts visible whenever the pause condition drops.
      if (blink_on_s) begin
        if (blink_cnt_r == BLINK_LAST) begin
          blink_cnt_r <= '0;
          blink_ph_r  <= ~blink_ph_r;
        end else begin
          blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
        end
      end else begin
        blink_cnt_r <= '0;
        blink_ph_r  <= 1'b0;
      end

      // Buzz is high for BUZZ_CYC cycles: the trigger edge plus BUZZ_CYC-1 countdown edges.
      prev_tt_r <= Tt;
      if (trig_s) begin
        buzz_cnt_r <= BUZZ_RELOAD;
        buzz       <= 1'b1;
      end else if (buzz_cnt_r != '0) begin
        buzz_cnt_r <= buzz_cnt_r - BUZZ_W'(1);
        buzz       <= 1'b1;
      end else begin
        buzz <= 1'b0;
      end

      an  <= (blink_on_s && blink_ph_r) ? 4'b1111 : ~(4'b0001 << idx_r);
      seg <= seg_s;
      dp  <= !((idx_r == 2'd2) && s);
    end
  end

endmodule

// File: tb/tb_wash_disp.sv
// Self-checking bench for wash_disp: directed scenarios plus random stimulus,
// compared every cycle against a cycle-count based behavioural model.
module tb_wash_disp;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 8;
  localparam int BUZZ_CYC  = 10;

  logic       ts = 1'b0;
  logic       rst, p, s;
  logic [5:0] Tt;
  logic [4:0] Tm;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, buzz;

  int checks = 0;
  int errors = 0;

  wash_disp #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .BUZZ_CYC(BUZZ_CYC)) dut (
    .ts(ts), .rst(rst), .p(p), .s(s), .Tt(Tt), .Tm(Tm),
    .an(an), .seg(seg), .dp(dp), .buzz(buzz)
  );

  always #5 ts = ~ts;

  function automatic logic [6:0] enc(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // ---------------- reference model ----------------
  int  k, brun, rem, conv, m_idx;
  int  snap_tt, snap_tm, disp_tt, disp_tm, prev_tt;
  bit  snap_vld, m_cond;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp, exp_buzz;

  function automatic logic [6:0] digit_seg(input int idx, input int vt, input int vm);
    case (idx)
      3: return (vt / 10 == 0) ? 7'h7F : enc(vt / 10);
      2: return enc(vt % 10);
      1: return (vm / 10 == 0) ? 7'h7F : enc(vm / 10);
      default: return enc(vm % 10);
    endcase
  endfunction

  always @(posedge ts) begin
    if (rst || !p) begin
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_buzz = 1'b0;
      k = 0; brun = 0; rem = 0; conv = 0; snap_vld = 0;
      disp_tt = 0; disp_tm = 0; prev_tt = 0; snap_tt = 0; snap_tm = 0;
    end else begin
      // outputs reflect the state held before this edge
      m_idx   = (k / SCAN_DIV) % 4;
      m_cond  = !s && (Tt != 6'd0);
      exp_an  = (m_cond && ((brun / BLINK_DIV) % 2 == 1)) ? 4'hF : ~(4'b0001 << m_idx);
      exp_seg = digit_seg(m_idx, disp_tt, disp_tm);
      exp_dp  = !(m_idx == 2 && s);
      if (prev_tt != 0 && Tt == 6'd0) rem = BUZZ_CYC;
      exp_buzz = (rem > 0);
      if (rem > 0) rem = rem - 1;
      prev_tt = int'(Tt);
      k = k + 1;
      brun = m_cond ? brun + 1 : 0;
      // conversion: detect at E, snapshot at E+1, display update at E+8
      if (conv > 0) begin
        if (conv == 8) begin
          snap_tt = int'(Tt); snap_tm = int'(Tm); snap_vld = 1;
        end
        conv = conv - 1;
        if (conv == 0) begin
          disp_tt = snap_tt; disp_tm = snap_tm;
        end
      end else if (!snap_vld || int'(Tt) != snap_tt || int'(Tm) != snap_tm) begin
        conv = 8;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check_all(input string tag);
    checks++;
    assert (an === exp_an) else begin
      errors++; $error("FAIL %s.an got=%b exp=%b", tag, an, exp_an);
    end
    checks++;
    assert (dp === exp_dp) else begin
      errors++; $error("FAIL %s.dp got=%b exp=%b", tag, dp, exp_dp);
    end
    checks++;
    assert (buzz === exp_buzz) else begin
      errors++; $error("FAIL %s.buzz got=%b exp=%b", tag, buzz, exp_buzz);
    end
    if (exp_an !== 4'hF || rst || !p) begin
      checks++;
      assert (seg === exp_seg) else begin
        errors++; $error("FAIL %s.seg got=%h exp=%h", tag, seg, exp_seg);
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge ts);
    @(negedge ts);
    check_all(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  // Scan 16 cycles and check each selected digit against fixed patterns.
  task automatic scan_expect(input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      tick(tag);
      checks++;
      case (an)
        4'b0111: begin assert (seg === e3) else begin errors++; $error("FAIL %s.d3 got=%h exp=%h", tag, seg, e3); end seen |= 8; end
        4'b1011: begin assert (seg === e2) else begin errors++; $error("FAIL %s.d2 got=%h exp=%h", tag, seg, e2); end seen |= 4; end
        4'b1101: begin assert (seg === e1) else begin errors++; $error("FAIL %s.d1 got=%h exp=%h", tag, seg, e1); end seen |= 2; end
        4'b1110: begin assert (seg === e0) else begin errors++; $error("FAIL %s.d0 got=%h exp=%h", tag, seg, e0); end seen |= 1; end
        default: begin assert (1'b0) else begin errors++; $error("FAIL %s.an got=%b exp=one-hot-low", tag, an); end end
      endcase
      checks++;
      assert (dp === !(an == 4'b1011 && s)) else begin
        errors++; $error("FAIL %s.dp got=%b an=%b", tag, dp, an);
      end
    end
    checks++;
    assert (seen == 15) else begin
      errors++; $error("FAIL %s.coverage got=%0d exp=15", tag, seen);
    end
  endtask

  int cnt;

  initial begin
    rst = 1'b1; p = 1'b1; s = 1'b1; Tt = 6'd21; Tm = 5'd4;
    @(negedge ts);

    // 1. reset holds display dark
    for (int i = 0; i < 3; i++) begin
      tick("reset");
      checks++;
      assert (an === 4'hF && seg === 7'h7F && dp === 1'b1 && buzz === 1'b0) else begin
        errors++; $error("FAIL reset got=%b/%h/%b/%b exp=1111/7f/1/0", an, seg, dp, buzz);
      end
    end

    // 2. first conversion and scanning
    rst = 1'b0;
    ticks(12, "conv1");
    scan_expect(7'h24, 7'h79, 7'h7F, 7'h19, "show21_4");

    // 3. input change mid-conversion
    Tt = 6'd45; Tm = 5'd12;
    ticks(3, "conv2a");
    Tt = 6'd33; Tm = 5'd0;
    ticks(22, "conv2b");
    scan_expect(7'h30, 7'h30, 7'h7F, 7'h40, "show33_0");

    // 4. pause blinking, then resume
    Tt = 6'd21; Tm = 5'd4; s = 1'b0;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      tick("blink");
      if (an == 4'hF) cnt++;
    end
    checks++;
    assert (cnt == 16) else begin
      errors++; $error("FAIL blink_dark got=%0d exp=16", cnt);
    end
    s = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick("resume");
      checks++;
      assert (an !== 4'hF) else begin
        errors++; $error("FAIL resume.an got=%b exp=scanning", an);
      end
    end

    // 5. buzzer
    Tt = 6'd1;
    ticks(3, "pre_buzz");
    Tt = 6'd0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick("buzz");
      if (buzz) cnt++;
    end
    checks++;
    assert (cnt == BUZZ_CYC) else begin
      errors++; $error("FAIL buzz_len got=%0d exp=%0d", cnt, BUZZ_CYC);
    end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick("hold0");
      if (buzz) cnt++;
    end
    checks++;
    assert (cnt == 0) else begin
      errors++; $error("FAIL hold0_buzz got=%0d exp=0", cnt);
    end
    Tt = 6'd1; tick("rebuzz");
    Tt = 6'd0; ticks(4, "rebuzz");
    p = 1'b0; tick("poff");
    checks++;
    assert (buzz === 1'b0 && an === 4'hF) else begin
      errors++; $error("FAIL poff got=%b/%b exp=0/1111", buzz, an);
    end
    Tt = 6'd5; tick("poff2");
    p = 1'b1; Tt = 6'd0; ticks(5, "pon_first");

    // 6. reset during shifting
    Tt = 6'd50; Tm = 5'd17;
    ticks(4, "pre_rst");
    rst = 1'b1; tick("rst_shift");
    checks++;
    assert (an === 4'hF && seg === 7'h7F) else begin
      errors++; $error("FAIL rst_shift got=%b/%h exp=1111/7f", an, seg);
    end
    rst = 1'b0;
    ticks(10, "reconv");
    scan_expect(7'h12, 7'h40, 7'h79, 7'h78, "show50_17");

    // random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) Tt = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      if ($urandom_range(0, 5) == 0) Tm = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) s = ~s;
      p   = ($urandom_range(0, 59) != 0);
      rst = ($urandom_range(0, 99) == 0);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
